// File: rtl/screen_seq_pkg.sv
// Shared types and constants for the OLED screen sequencer.
//   state_t   : sequencer FSM states
//   BLACK     : pixel value driven while idle or blanking (RGB565)
//   DEF_PIX_W : default pixel width
package screen_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [15:0] BLACK     = 16'h0000;
  localparam int          DEF_PIX_W = 16;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced level button.
// The previous-sample register updates every cycle. A level that is already
// high on the first sampled cycle produces one press. The consumer decides
// whether to act on that press.
//   clk   : clock
//   rst_n : synchronous reset, active low (previous sample cleared to 0)
//   din   : debounced button level
//   press : high for the cycle where din is high and the previous sample was low
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic press
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= din;
  end

  assign press = din & ~prev_q;

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer for the OLED game path.
// Selects one of NUM_SCREENS generator outputs and supports next/prev
// navigation with wrap or saturate at the ends. After each index change it
// forces the output black for BLANK_CYCLES cycles.
// Optional feature macro SCREEN_SEQ_AUTO_EN: when it is defined, the index
// auto-advances after AUTO_TICKS tick strobes with no button press.
//
// State table:
//   state | meaning
//   IDLE  | game disabled; oled_data black; index held at 0
//   SHOW  | selected screen drives oled_data (black while blanking)
//
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   en           : game enable; low returns to IDLE
//   btn_next/prev: debounced level buttons; each rising edge is one press
//   tick         : slow strobe for auto-advance
//   screen_data  : flattened generator outputs; screen i is [i*PIX_W +: PIX_W]
//   oled_data    : selected pixel (combinational)
//   screen_idx   : current screen index (registered)
//   active       : high in SHOW (decoded directly from the state register)
module screen_sequencer
  import screen_seq_pkg::*;
#(
  parameter int NUM_SCREENS  = 13,
  parameter int PIX_W        = DEF_PIX_W,
  parameter int WRAP         = 1,
  parameter int BLANK_CYCLES = 0,
  parameter int AUTO_TICKS   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           btn_next,
  input  logic                           btn_prev,
  input  logic                           tick,
  input  logic [NUM_SCREENS*PIX_W-1:0]   screen_data,
  output logic [PIX_W-1:0]               oled_data,
  output logic [$clog2(NUM_SCREENS)-1:0] screen_idx,
  output logic                           active
);

  localparam int IDX_W   = $clog2(NUM_SCREENS);
  localparam int BLANK_W = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_SCREENS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               press_next, press_prev;
  logic               go_next, go_prev;

  btn_edge u_next_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_next),
    .press (press_next)
  );

  btn_edge u_prev_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_prev),
    .press (press_prev)
  );

`ifdef SCREEN_SEQ_AUTO_EN
  localparam int AUTO_W = (AUTO_TICKS < 2) ? 1 : $clog2(AUTO_TICKS);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TICKS - 1);
  logic [AUTO_W-1:0] auto_q, auto_d;
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      blank_q <= '0;
`ifdef SCREEN_SEQ_AUTO_EN
      auto_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
`ifdef SCREEN_SEQ_AUTO_EN
      auto_q  <= auto_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blank_d = blank_q;
    go_next = 1'b0;
    go_prev = 1'b0;
`ifdef SCREEN_SEQ_AUTO_EN
    auto_d  = auto_q;
`endif
    case (state_q)
      IDLE: begin
        idx_d   = '0;
        blank_d = '0;
`ifdef SCREEN_SEQ_AUTO_EN
        auto_d  = '0;
`endif
        if (en) state_d = SHOW;
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          blank_d = '0;
`ifdef SCREEN_SEQ_AUTO_EN
          auto_d  = '0;
`endif
        end else begin
          // Simultaneous presses cancel each other.
          go_next = press_next & ~press_prev;
          go_prev = press_prev & ~press_next;
`ifdef SCREEN_SEQ_AUTO_EN
          // Any press, including a cancelled pair, restarts the auto count
          // and takes priority over a coincident tick.
          if (press_next | press_prev) begin
            auto_d = '0;
          end else if (tick) begin
            if (auto_q == AUTO_LAST) begin
              auto_d  = '0;
              go_next = 1'b1;
            end else begin
              auto_d = auto_q + AUTO_W'(1);
            end
          end
`endif
          if (blank_q != '0) blank_d = blank_q - BLANK_W'(1);

          if (go_next) begin
            if (idx_q == LAST_IDX) idx_d = (WRAP != 0) ? '0 : idx_q;
            else                   idx_d = idx_q + IDX_W'(1);
          end else if (go_prev) begin
            if (idx_q == '0) idx_d = (WRAP != 0) ? LAST_IDX : idx_q;
            else             idx_d = idx_q - IDX_W'(1);
          end

          // Only a real index change restarts blanking; saturated presses do not.
          if (idx_d != idx_q) blank_d = BLANK_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oled_data = PIX_W'(BLACK);
    if (state_q == SHOW && blank_q == '0)
      oled_data = screen_data[idx_q*PIX_W +: PIX_W];
  end

  assign screen_idx = idx_q;
  assign active     = (state_q == SHOW);

endmodule
